// File: rtl/shapool_pkg.sv
// Constants and the result-collector state encoding shared by the shapool
// pool, result and IO blocks.
package shapool_pkg;
  localparam int NONCE_WIDTH_DEF    = 32;
  localparam int POOL_SIZE_LOG2_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    HALTED = 2'b10
  } rc_state_e;
endpackage

// File: rtl/result_collector_if.sv
// Pool-side success/job signals and IO-side result stream of result_collector.
interface result_collector_if import shapool_pkg::*; #(
  parameter int NONCE_WIDTH     = NONCE_WIDTH_DEF,
  parameter int POOL_SIZE_LOG2  = POOL_SIZE_LOG2_DEF,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic                      job_start;
  logic                      shapool_success;
  logic [NONCE_WIDTH-1:0]    shapool_nonce;
  logic [POOL_SIZE_LOG2-1:0] shapool_index;
  logic                      result_valid;
  logic [NONCE_WIDTH-1:0]    result_data;
  logic                      result_ready;
  logic                      pool_halt;
  logic                      overflow;
  logic [FIFO_DEPTH_LOG2:0]  result_count;

  modport master (
    output job_start, shapool_success, shapool_nonce, shapool_index, result_ready,
    input  result_valid, result_data, pool_halt, overflow, result_count
  );

  modport slave (
    input  job_start, shapool_success, shapool_nonce, shapool_index, result_ready,
    output result_valid, result_data, pool_halt, overflow, result_count
  );
endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO with separate occupancy count; head output
// holds the last shown word while empty.
module result_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = empty ? hold_q : mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Track the visible head so it survives a drain or a clear.
    hold_d   = empty ? hold_q : mem_q[rd_ptr_q];
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end
endmodule

// File: rtl/result_collector.sv
// Corrects winning nonces from the shapool cores, buffers them for the IO block
// and back-pressures the pool. RESULT_COLLECTOR_DEDUP_EN drops repeat nonces.
module result_collector import shapool_pkg::*; #(
  parameter int NONCE_WIDTH     = NONCE_WIDTH_DEF,
  parameter int POOL_SIZE_LOG2  = POOL_SIZE_LOG2_DEF,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input logic               clk,
  input logic               reset,
  result_collector_if.slave bus
);
  localparam int L     = NONCE_WIDTH - POOL_SIZE_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  rc_state_e              state_q, state_d;
  logic                   corr_vld_q, corr_vld_d;
  logic [NONCE_WIDTH-1:0] corr_q, corr_d;
  logic                   ovf_q, ovf_d;
  logic                   push_req, accept, pop, full, empty;
  logic [CW-1:0]          count, count_nxt;

  // The index field is rebuilt from the reporting core, so the decrement
  // never borrows into it.
  always_comb begin
    corr_vld_d = bus.shapool_success && (state_q != IDLE) && !bus.job_start;
    corr_d     = {bus.shapool_index, bus.shapool_nonce[L-1:0] - L'(1)};
  end

`ifdef RESULT_COLLECTOR_DEDUP_EN
  logic [NONCE_WIDTH-1:0] last_q, last_d;
  logic                   last_vld_q, last_vld_d;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (bus.job_start) begin
      last_vld_d = 1'b0;
    end else if (accept) begin
      last_d     = corr_q;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign push_req = corr_vld_q && !(last_vld_q && (last_q == corr_q));
`else
  assign push_req = corr_vld_q;
`endif

  assign pop       = bus.result_ready && !empty;
  assign accept    = push_req && !bus.job_start && (!full || pop);
  assign count_nxt = count + CW'(accept) - CW'(pop);

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    if (bus.job_start) begin
      state_d = ARMED;
      ovf_d   = 1'b0;
    end else begin
      if (push_req && full && !pop) ovf_d = 1'b1;
      if (state_q != IDLE) state_d = (count_nxt == CW'(DEPTH)) ? HALTED : ARMED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      corr_vld_q <= 1'b0;
      corr_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      corr_vld_q <= corr_vld_d;
      corr_q     <= corr_d;
      ovf_q      <= ovf_d;
    end
  end

  result_fifo #(
    .WIDTH      (NONCE_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.job_start),
    .push      (accept),
    .push_data (corr_q),
    .pop       (pop),
    .head_data (bus.result_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.result_valid = !empty;
  assign bus.result_count = count;
  assign bus.pool_halt    = (state_q == HALTED);
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: queue-based reference model plus a
// negedge monitor; directed cases followed by randomized traffic.
module tb_result_collector;
  localparam int NW = 32, PL = 2, FD = 2;
  localparam int D  = 1 << FD;
  localparam int L  = NW - PL;
`ifdef RESULT_COLLECTOR_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  result_collector_if #(.NONCE_WIDTH(NW), .POOL_SIZE_LOG2(PL), .FIFO_DEPTH_LOG2(FD)) bus();

  result_collector #(.NONCE_WIDTH(NW), .POOL_SIZE_LOG2(PL), .FIFO_DEPTH_LOG2(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NW-1:0] exp_q[$];
  bit            m_armed, m_pv, m_ovf, m_lv, m_pop, m_dup;
  int            m_cnt;
  logic [NW-1:0] m_pd, m_last, last_shown;

  // Winner = core index * 2^L + (low field - 1) modulo 2^L.
  function automatic logic [NW-1:0] correct(input logic [NW-1:0] n, input logic [PL-1:0] i);
    logic [63:0] span, lo;
    span = 64'd1 << L;
    lo   = ((64'(n) % span) + span - 64'd1) % span;
    return NW'(64'(i) * span + lo);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy, pending correction, sticky overflow.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_armed = 0; m_cnt = 0; m_pv = 0; m_ovf = 0; m_lv = 0;
      exp_q.delete();
    end else if (bus.job_start) begin
      m_armed = 1; m_cnt = 0; m_pv = 0; m_ovf = 0; m_lv = 0;
      exp_q.delete();
    end else begin
      m_pop = bus.result_ready && (m_cnt > 0);
      if (m_pv) begin
        m_dup = DEDUP && m_lv && (m_pd == m_last);
        if (!m_dup) begin
          if (m_cnt < D || m_pop) begin
            exp_q.push_back(m_pd);
            m_cnt++;
            m_last = m_pd;
            m_lv   = 1;
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (m_pop) m_cnt--;
      m_pv = m_armed && bus.shapool_success;
      m_pd = correct(bus.shapool_nonce, bus.shapool_index);
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on handshake.
  initial forever begin
    @(negedge clk);
    if (reset) last_shown = '0;
    chk("valid", 64'(bus.result_valid), 64'(m_cnt > 0));
    chk("count", 64'(bus.result_count), 64'(m_cnt));
    chk("halt", 64'(bus.pool_halt), 64'(m_armed && m_cnt == D));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_unexpected: got %0h expected no entry at %0t", bus.result_data, $time);
      end else begin
        chk("data", 64'(bus.result_data), 64'(exp_q[0]));
        last_shown = exp_q[0];
        if (bus.result_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("data_hold", 64'(bus.result_data), 64'(last_shown));
    end
  end

  task automatic step(input bit js, input bit s, input logic [NW-1:0] n,
                      input logic [PL-1:0] i, input bit rdy);
    bus.job_start       = js;
    bus.shapool_success = s;
    bus.shapool_nonce   = n;
    bus.shapool_index   = i;
    bus.result_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input bit rdy);
    repeat (k) step(1'b0, 1'b0, '0, '0, rdy);
  endtask

  logic [NW-1:0] rn, last_n;
  logic [PL-1:0] ri;
  bit            rs, rj, rr;
  int            rdy_bias;

  initial begin
    bus.job_start = 0; bus.shapool_success = 0; bus.shapool_nonce = '0;
    bus.shapool_index = '0; bus.result_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_count", 64'(bus.result_count), 64'd0);
    chk("rst_data", 64'(bus.result_data), 64'd0);

    // IDLE ignores successes.
    step(0, 1, 32'h0000_0077, 0, 0);
    idle(2, 0);
    chk("idle_ignored", 64'(bus.result_valid), 64'd0);

    // Basic correction and 2-cycle latency.
    step(1, 0, '0, '0, 0);
    step(0, 1, 32'h0000_1235, 0, 0);
    idle(1, 0);
    chk("lat_valid", 64'(bus.result_valid), 64'd1);
    chk("basic_data", 64'(bus.result_data), 64'h0000_1234);
    idle(1, 1);

    // Low-field wrap; top raw bits ignored.
    step(0, 1, 32'hC000_0000, 3, 0);
    idle(1, 0);
    chk("wrap_data", 64'(bus.result_data), 64'hFFFF_FFFF);
    idle(1, 1);

    // Five back-to-back into depth 4.
    for (int k = 0; k < 5; k++) step(0, 1, 32'h100 + k, 0, 0);
    idle(1, 0);
    chk("full_count", 64'(bus.result_count), 64'd4);
    chk("full_halt", 64'(bus.pool_halt), 64'd1);
    chk("full_ovf", 64'(bus.overflow), 64'd1);
    chk("full_head", 64'(bus.result_data), 64'h0000_00FF);
    idle(1, 1);
    chk("unhalt", 64'(bus.pool_halt), 64'd0);
    idle(4, 1);

    // Full with write and pop on the same edge.
    step(1, 0, '0, '0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 32'h200 + k, 1, 0);
    idle(1, 0);
    step(0, 1, 32'h300, 2, 0);
    idle(1, 1);
    chk("pushpop_count", 64'(bus.result_count), 64'd4);
    chk("pushpop_ovf", 64'(bus.overflow), 64'd0);
    idle(6, 1);

    // job_start flushes a partly full buffer and clears overflow.
    step(1, 0, '0, '0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 32'h400 + k, 0, 0);
    idle(1, 0);
    idle(1, 1);
    chk("pre_js_count", 64'(bus.result_count), 64'd3);
    step(1, 0, '0, '0, 0);
    chk("js_count", 64'(bus.result_count), 64'd0);
    chk("js_valid", 64'(bus.result_valid), 64'd0);
    chk("js_ovf", 64'(bus.overflow), 64'd0);
    step(0, 1, 32'h55, 0, 0);
    idle(1, 0);
    chk("js_armed", 64'(bus.result_valid), 64'd1);
    idle(1, 1);

    // Repeated nonce from the same core.
    step(0, 1, 32'h10, 1, 0);
    step(0, 1, 32'h10, 1, 0);
    idle(1, 0);
    chk("dup_count", 64'(bus.result_count), DEDUP ? 64'd1 : 64'd2);
    chk("dup_data", 64'(bus.result_data), 64'h4000_000F);
    idle(3, 1);

    // Randomized traffic with a mid-run reset.
    last_n = 32'h1234_5678;
    rdy_bias = 1;
    for (int k = 0; k < 2000; k++) begin
      if (k % 200 == 0) rdy_bias = $urandom_range(0, 3);
      if (k == 1000) begin
        reset = 1;
        idle(2, 0);
        reset = 0;
        step(1, 0, '0, '0, 0);
      end
      rj = ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 1) == 1);
      rn = ($urandom_range(0, 3) == 0) ? last_n : NW'($urandom);
      ri = PL'($urandom);
      rr = ($urandom_range(0, 3) < rdy_bias);
      last_n = rn;
      step(rj, rs, rn, ri, rr);
    end
    idle(10, 1);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
